// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: queues MMIO writes, launches one byte per frame.
// Define UART_TX_FIFO_OVF_EN to add the sticky o_overflow flag and its i_ovf_clr input.
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [DATA_W-1:0]        i_wr_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_tx_start,
    output logic [DATA_W-1:0]        o_tx_data,
`ifdef UART_TX_FIFO_OVF_EN
    output logic                     o_overflow,
    input  logic                     i_ovf_clr,
`endif
    input  logic                     i_tx_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_BUSY,
        WAIT_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       level_q, level_d;
    logic                full_q, empty_q;
    logic                start_q, start_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                push, pop;
    logic [DATA_W-1:0]   mem [DEPTH];

    // A full FIFO drops the write even when a pop frees a slot on the same edge.
    assign push = i_wr_en && !full_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty_q && !i_tx_busy) begin
                    pop     = 1'b1;
                    data_d  = mem[rd_ptr_q[AW-1:0]];
                    start_d = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!i_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = wr_ptr_d - rd_ptr_d;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            start_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= (level_d == PW'(DEPTH));
            empty_q  <= (level_d == '0);
            start_q  <= start_d;
            data_q   <= data_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= i_wr_data;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            ovf_q <= 1'b0;
        end else if (i_wr_en && full_q) begin
            ovf_q <= 1'b1;
        end else if (i_ovf_clr) begin
            ovf_q <= 1'b0;
        end
    end

    assign o_overflow = ovf_q;
`endif

    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_level    = level_q;
    assign o_tx_start = start_q;
    assign o_tx_data  = data_q;

endmodule
